// File: rtl/alu_cmd_sequencer_if.sv
// Bundle of the command, response and ALU buses around alu_cmd_sequencer.
// The slave modport is the sequencer's view. The master modport is the view of the
// environment that drives commands, consumes responses and hosts the ALU.
interface alu_cmd_sequencer_if #(
   parameter int WIDTH = 4,
   parameter int CNT_W = 3
);
   // command channel
   logic             cmd_valid;
   logic             cmd_ready;
   logic             cmd_load;
   logic [2:0]       cmd_op;
   logic [WIDTH-1:0] cmd_operand;
   logic [CNT_W-1:0] cmd_count;
   // ALU operand/result bus
   logic [WIDTH-1:0] alu_a;
   logic [WIDTH-1:0] alu_b;
   logic [2:0]       alu_op;
   logic [WIDTH-1:0] alu_result;
   logic             alu_zero;
   logic             alu_carry;
   // response channel
   logic             rsp_valid;
   logic             rsp_ready;
   logic [WIDTH-1:0] rsp_acc;
   logic             rsp_zero;
   logic             rsp_carry;

   modport slave (
      input  cmd_valid, cmd_load, cmd_op, cmd_operand, cmd_count,
      output cmd_ready,
      output alu_a, alu_b, alu_op,
      input  alu_result, alu_zero, alu_carry,
      output rsp_valid, rsp_acc, rsp_zero, rsp_carry,
      input  rsp_ready
   );

   modport master (
      output cmd_valid, cmd_load, cmd_op, cmd_operand, cmd_count,
      input  cmd_ready,
      input  alu_a, alu_b, alu_op,
      output alu_result, alu_zero, alu_carry,
      input  rsp_valid, rsp_acc, rsp_zero, rsp_carry,
      output rsp_ready
   );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// Command-driven accumulator controller for the 4-bit combinational ALU.
// A command either loads the accumulator or applies one ALU opcode 0..2^CNT_W-1
// times. The final accumulator, zero flag and sticky carry are then returned.
// Every output is a flop or a decode of the state flop.
module alu_cmd_sequencer #(
   parameter int WIDTH = 4,
   parameter int CNT_W = 3
) (
   input logic               clk,
   input logic               rst_n,
   alu_cmd_sequencer_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] operand_q, operand_d;
   logic [2:0]       op_q, op_d;
   logic [CNT_W-1:0] remaining_q, remaining_d;
   logic             zero_q, zero_d;
   logic             carry_q, carry_d;

   logic cmd_fire;
   logic cmd_short;

   // A command is taken only in IDLE, so cmd_valid in any other state is simply not consumed.
   assign cmd_fire  = (state_q == S_IDLE) && bus.cmd_valid;
   // A load, or a repeat count of zero, skips EXEC and goes straight to RESP.
   assign cmd_short = bus.cmd_load || (bus.cmd_count == '0);

   // State and datapath registers. Reset discards any in-flight command.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         acc_q       <= '0;
         operand_q   <= '0;
         op_q        <= 3'b000;
         remaining_q <= '0;
         zero_q      <= 1'b1;
         carry_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         operand_q   <= operand_d;
         op_q        <= op_d;
         remaining_q <= remaining_d;
         zero_q      <= zero_d;
         carry_q     <= carry_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (cmd_fire) begin
               state_d = cmd_short ? S_RESP : S_EXEC;
            end
         end
         // "<= 1" rather than "== 1": a stray zero count can never stall EXEC.
         S_EXEC: begin
            if (remaining_q <= CNT_W'(1)) begin
               state_d = S_RESP;
            end
         end
         S_RESP: begin
            if (bus.rsp_ready) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Datapath next values. The only arithmetic done here is the count decrement; the ALU computes the rest.
   always_comb begin
      acc_d       = acc_q;
      operand_d   = operand_q;
      op_d        = op_q;
      remaining_d = remaining_q;
      zero_d      = zero_q;
      carry_d     = carry_q;
      case (state_q)
         S_IDLE: begin
            if (cmd_fire) begin
               carry_d = 1'b0;
               if (bus.cmd_load) begin
                  // Leave alu_op/alu_b as they were: a load does not use the ALU.
                  acc_d  = bus.cmd_operand;
                  zero_d = (bus.cmd_operand == '0);
               end else begin
                  op_d      = bus.cmd_op;
                  operand_d = bus.cmd_operand;
                  if (bus.cmd_count == '0) begin
                     zero_d = (acc_q == '0);
                  end else begin
                     remaining_d = bus.cmd_count;
                  end
               end
            end
         end
         // The ALU is combinational: take its result in the same cycle the operands are presented.
         S_EXEC: begin
            acc_d       = bus.alu_result;
            zero_d      = bus.alu_zero;
            carry_d     = carry_q | bus.alu_carry;
            remaining_d = remaining_q - CNT_W'(1);
         end
         default: ;
      endcase
   end

   // Outputs: decodes of the state flop and direct register taps.
   always_comb begin
      bus.cmd_ready = (state_q == S_IDLE);
      bus.rsp_valid = (state_q == S_RESP);
      bus.rsp_acc   = acc_q;
      bus.rsp_zero  = zero_q;
      bus.rsp_carry = carry_q;
      bus.alu_a     = acc_q;
      bus.alu_b     = operand_q;
      bus.alu_op    = op_q;
   end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer. It provides a behavioural 4-bit ALU and a
// command-level reference model of the accumulator. It runs directed scenarios,
// then randomized commands with random response back-pressure.
module tb_alu_cmd_sequencer;
   localparam int WIDTH = 4;
   localparam int CNT_W = 3;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   failures = 0;
   logic [WIDTH-1:0] m_acc;      // reference accumulator
   logic [WIDTH:0]   alu_out;

   alu_cmd_sequencer_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

   alu_cmd_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Reference ALU: {carry, result}. For SUB, the carry is the borrow.
   function automatic logic [WIDTH:0] alu_ref(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                              input logic [2:0] op);
      case (op)
         3'd0:    alu_ref = {1'b0, a} + {1'b0, b};
         3'd1:    alu_ref = {1'b0, a} - {1'b0, b};
         3'd2:    alu_ref = {1'b0, a & b};
         3'd3:    alu_ref = {1'b0, a | b};
         3'd4:    alu_ref = {1'b0, a ^ b};
         3'd5:    alu_ref = {1'b0, ~a};
         3'd6:    alu_ref = {1'b0, ~(a & b)};
         default: alu_ref = {1'b0, ~(a | b)};
      endcase
   endfunction

   // The ALU instance the sequencer drives.
   always_comb alu_out = alu_ref(bus.alu_a, bus.alu_b, bus.alu_op);
   assign bus.alu_result = alu_out[WIDTH-1:0];
   assign bus.alu_carry  = alu_out[WIDTH];
   assign bus.alu_zero   = (alu_out[WIDTH-1:0] == '0);

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one command, track it through EXEC, stall the response for "stall" cycles, then consume it.
   task automatic run_cmd(input bit load, input logic [2:0] op, input logic [WIDTH-1:0] operand,
                          input logic [CNT_W-1:0] count, input int stall);
      logic [WIDTH-1:0] seq [0:(1<<CNT_W)];
      logic [WIDTH:0]   r;
      logic [WIDTH-1:0] held;
      logic             exp_carry;
      int               exp_lat;
      int               cyc;
      int               waitc;
      waitc = 0;
      while (!bus.cmd_ready && waitc < 20) begin
         tick();
         waitc++;
      end
      check_val("cmd_ready_idle", 32'(bus.cmd_ready), 32'd1);
      // Model: apply the opcode "count" times to the accumulator.
      exp_carry = 1'b0;
      seq[0] = m_acc;
      if (load) begin
         m_acc   = operand;
         exp_lat = 1;
      end else if (count == '0) begin
         exp_lat = 1;
      end else begin
         for (int k = 1; k <= int'(count); k++) begin
            r = alu_ref(seq[k-1], operand, op);
            seq[k] = r[WIDTH-1:0];
            exp_carry = exp_carry | r[WIDTH];
         end
         m_acc   = seq[count];
         exp_lat = int'(count) + 1;
      end
      bus.cmd_load    = load;
      bus.cmd_op      = op;
      bus.cmd_operand = operand;
      bus.cmd_count   = count;
      bus.cmd_valid   = 1'b1;
      tick();
      // Scramble the command fields so that anything the DUT failed to latch shows up.
      bus.cmd_valid   = 1'b0;
      bus.cmd_operand = WIDTH'($urandom);
      bus.cmd_op      = 3'($urandom);
      bus.cmd_count   = CNT_W'($urandom);
      bus.cmd_load    = 1'($urandom);
      cyc = 1;
      while (!bus.rsp_valid && cyc < 20) begin
         if (!load && cyc <= int'(count)) begin
            check_val("alu_a_seq", 32'(bus.alu_a), 32'(seq[cyc-1]));
            check_val("alu_b", 32'(bus.alu_b), 32'(operand));
            check_val("alu_op", 32'(bus.alu_op), 32'(op));
         end
         tick();
         cyc++;
      end
      check_val("rsp_latency", 32'(cyc), 32'(exp_lat));
      check_val("rsp_valid", 32'(bus.rsp_valid), 32'd1);
      check_val("rsp_acc", 32'(bus.rsp_acc), 32'(m_acc));
      check_val("rsp_zero", 32'(bus.rsp_zero), 32'(m_acc == '0));
      check_val("rsp_carry", 32'(bus.rsp_carry), 32'(exp_carry));
      held = bus.rsp_acc;
      bus.rsp_ready = 1'b0;
      for (int i = 0; i < stall; i++) begin
         // Commands offered while a response is pending must be ignored.
         bus.cmd_valid   = 1'($urandom);
         bus.cmd_load    = 1'b1;
         bus.cmd_operand = WIDTH'($urandom);
         tick();
         check_val("stall_rsp_valid", 32'(bus.rsp_valid), 32'd1);
         check_val("stall_rsp_acc", 32'(bus.rsp_acc), 32'(held));
         check_val("stall_cmd_ready", 32'(bus.cmd_ready), 32'd0);
      end
      bus.cmd_valid = 1'b0;
      bus.rsp_ready = 1'b1;
      tick();
      bus.rsp_ready = 1'b0;
      check_val("post_rsp_cmd_ready", 32'(bus.cmd_ready), 32'd1);
      check_val("post_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      $display("cmd load=%0d op=%0d operand=%0d count=%0d stall=%0d -> acc=%0d zero=%0d carry=%0d lat=%0d",
               load, op, operand, count, stall, bus.rsp_acc, bus.rsp_zero, bus.rsp_carry, cyc);
   endtask

   // Hold reset for a few cycles while offering a command, which must not be captured.
   task automatic hold_reset(input int cycles);
      rst_n = 1'b0;
      #1;
      for (int i = 0; i < cycles; i++) begin
         bus.cmd_valid   = 1'b1;
         bus.cmd_load    = 1'b1;
         bus.cmd_operand = 4'd5;
         check_val("rst_rsp_acc", 32'(bus.rsp_acc), 32'd0);
         check_val("rst_alu_a", 32'(bus.alu_a), 32'd0);
         check_val("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
         check_val("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
         check_val("rst_zero", 32'(bus.rsp_zero), 32'd1);
         check_val("rst_carry", 32'(bus.rsp_carry), 32'd0);
         tick();
      end
      bus.cmd_valid = 1'b0;
      rst_n = 1'b1;
      m_acc = '0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bus.cmd_valid   = 1'b0;
      bus.cmd_load    = 1'b0;
      bus.cmd_op      = 3'd0;
      bus.cmd_operand = '0;
      bus.cmd_count   = '0;
      bus.rsp_ready   = 1'b0;
      m_acc           = '0;
      tick();
      hold_reset(3);
      tick();

      // Directed scenarios
      run_cmd(1'b1, 3'd0, 4'd5, 3'd0, 0);   // LOAD 5
      run_cmd(1'b1, 3'd0, 4'd3, 3'd0, 0);   // LOAD 3
      run_cmd(1'b0, 3'd0, 4'd3, 3'd5, 0);   // ADD 3 x5 -> 2, carry
      run_cmd(1'b1, 3'd0, 4'd5, 3'd0, 1);   // LOAD 5
      run_cmd(1'b0, 3'd1, 4'd5, 3'd1, 0);   // SUB 5 -> 0
      run_cmd(1'b0, 3'd1, 4'd1, 3'd1, 0);   // SUB 1 -> 15, borrow
      run_cmd(1'b1, 3'd0, 4'd0, 3'd0, 0);   // LOAD 0
      run_cmd(1'b0, 3'd4, 4'd7, 3'd0, 0);   // XOR count 0
      run_cmd(1'b1, 3'd0, 4'd9, 3'd0, 0);   // LOAD 9
      run_cmd(1'b0, 3'd5, 4'd0, 3'd2, 0);   // NOT x2 -> 9
      run_cmd(1'b0, 3'd0, 4'd1, 3'd1, 4);   // ADD 1 -> 10, stalled response

      // Reset during the third EXEC cycle of OR 1 x7
      bus.cmd_load    = 1'b0;
      bus.cmd_op      = 3'd3;
      bus.cmd_operand = 4'd1;
      bus.cmd_count   = 3'd7;
      bus.cmd_valid   = 1'b1;
      tick();
      bus.cmd_valid = 1'b0;
      tick();
      tick();
      hold_reset(2);
      for (int i = 0; i < 10; i++) begin
         tick();
         check_val("post_rst_no_rsp", 32'(bus.rsp_valid), 32'd0);
         check_val("post_rst_acc", 32'(bus.rsp_acc), 32'd0);
      end
      run_cmd(1'b1, 3'd0, 4'd2, 3'd0, 0);   // LOAD 2

      // Randomized commands
      for (int n = 0; n < 80; n++) begin
         run_cmd(($urandom_range(0, 4) == 0), 3'($urandom), WIDTH'($urandom),
                 CNT_W'($urandom), int'($urandom_range(0, 3)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/alu_cmd_sequencer.md
# alu_cmd_sequencer

Command-driven accumulator controller that issues operations to the team's 4-bit combinational ALU. It accepts commands over a valid/ready handshake and holds a WIDTH-bit accumulator. Each command is applied to the ALU 1..N times, and the final accumulator, zero flag and sticky carry are returned over a second valid/ready handshake. It sits between a command source (host FSM or testbench) and the ALU instance, and is the ALU's only initiator.

## Interface
- WIDTH, 4: data width; must equal the ALU operand width.
- CNT_W, 3: repeat-count width; max repeat is 2^CNT_W-1.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  sequencer can accept a command.
- cmd_load  in  1  1: load accumulator with cmd_operand, no ALU op.
- cmd_op  in  3  ALU opcode: ADD 000, SUB 001, AND 010, OR 011, XOR 100, NOT 101, NAND 110, NOR 111.
- cmd_operand  in  WIDTH  B operand, or load value.
- cmd_count  in  CNT_W  number of ALU applications.
- alu_a  out  WIDTH  to ALU A; always the accumulator.
- alu_b  out  WIDTH  to ALU B; always the latched operand.
- alu_op  out  3  to ALU Op; always the latched opcode.
- alu_result  in  WIDTH  from ALU Result.
- alu_zero  in  1  from ALU Zero.
- alu_carry  in  1  from ALU Carry. For SUB this is bit WIDTH of A-B, i.e. 1 on borrow.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_acc  out  WIDTH  accumulator value; valid while rsp_valid.
- rsp_zero  out  1  final accumulator == 0.
- rsp_carry  out  1  OR of alu_carry over all applications of the command.

## Operation
- States:
  - IDLE: cmd_ready=1.
  - EXEC: ALU applications in progress.
  - RESP: rsp_valid=1.
- Outputs are registers or decodes of the state register. There is no combinational path from cmd_valid or rsp_ready to any output.
- IDLE, on cmd_valid && cmd_ready: latch op, operand and count; clear sticky carry.
  - cmd_load=1: acc<=cmd_operand, zero<=(cmd_operand==0); go to RESP. cmd_op and cmd_count are ignored.
  - cmd_load=0, cmd_count==0: acc unchanged, zero<=(acc==0), carry=0; go to RESP.
  - Otherwise: remaining<=cmd_count; go to EXEC.
- EXEC, every cycle:
  - acc<=alu_result; zero<=alu_zero; carry<=carry|alu_carry; remaining<=remaining-1.
  - When remaining==1, go to RESP.
  - The ALU is combinational, so its result is sampled in the same cycle the operands are presented.
- RESP: hold rsp_acc, rsp_zero and rsp_carry stable while rsp_valid && !rsp_ready. On rsp_ready, go to IDLE.
- Accumulator persists across commands and is modified only by load or EXEC.
- Arithmetic is modulo 2^WIDTH, exactly as the ALU produces it. The sequencer performs no arithmetic of its own except the remaining-count decrement.
- cmd_valid outside IDLE is ignored; the command is not consumed.
- Reset (asynchronous, any state):
  - state=IDLE, acc=0, operand=0, op=000, remaining=0.
  - Flags: zero=1, carry=0.
  - Outputs: rsp_valid=0, rsp_acc=0, cmd_ready=1.
  - Any in-flight command is discarded. No command is captured while rst_n=0.

## Timing
- Command accepted at edge T.
- EXEC occupies edges T+1..T+count.
- rsp_valid rises after edge T+count, so it is visible in cycle T+count+1.
- Load or count==0: rsp_valid is visible in cycle T+1.
- Response consumed at edge R: cmd_ready=1 from cycle R+1.
- Minimum command-to-command spacing is 3 cycles for EXEC commands and 2 cycles for load/count==0.
- alu_a, alu_b and alu_op change only on clock edges.

## Test plan
- Reset, then LOAD 5 -> rsp in cycle T+1 with acc=5, zero=0, carry=0. acc=0 and rsp_valid=0 throughout reset.
- LOAD 3, then ADD operand 3 count 5 -> acc=2 (18 mod 16), carry=1, zero=0. rsp_valid in cycle T+6; alu_a sequence 3,6,9,12,15.
- LOAD 5, SUB 5 count 1 -> acc=0, zero=1, carry=0. Then SUB 1 count 1 -> acc=15, carry=1 (borrow), zero=0.
- XOR 7 count 0 with acc=0 -> rsp in cycle T+1, acc=0, zero=1, carry=0. Then LOAD 9, NOT count 2 -> acc=9.
- After ADD 1 count 1 from acc=9: hold rsp_ready=0 for 4 cycles while pulsing cmd_valid -> rsp_acc=10 stable, cmd_ready=0, no command consumed. Raise rsp_ready -> cmd_ready=1 next cycle.
- Start OR 1 count 7; assert rst_n=0 during 3rd EXEC cycle -> immediately acc=0, rsp_valid=0, cmd_ready=1. No response after release; next LOAD 2 returns acc=2.
